axis_row_generator: RTL and testbench
=====================================

Name: axis_row_generator

Overview:
- Upstream source for the row-data consumer. Emits complete LVDS-style data rows on a 512-bit AXI Stream.
- Each row is 1 header beat, then DATA_CYCLES data beats, then 1 trailer beat.
- Data beats carry the lane-rotated integrity pattern the consumer checks, so a dataset can be bulk-tested end to end.
- A software-controlled error-injection input confirms the downstream error counter works.

Parameters:
- DATA_WIDTH, 512: stream width. Only 512 is supported (16 lanes x 32 bits).
- DATA_CYCLES, 32: data beats per row.
- GAP_CYCLES, 0: idle cycles (TVALID=0) inserted after each trailer handshake.
- SEED, 32'h0000_0001: starting pattern word for each dataset.

Ports:
- clk  in  1  single clock for the whole block.
- reset  in  1  asynchronous, active-high.
- start  in  1  pulse; begins a dataset when idle.
- row_count  in  32  rows in dataset; latched on an accepted start.
- abort  in  1  pulse; stop at the next row boundary.
- inject_error  in  1  pulse; corrupt the next data beat.
- busy  out  1  high from accepted start until dataset end.
- done  out  1  one-cycle pulse at dataset end.
- rows_sent  out  64  trailers handshaken this dataset.
- AXIS_OUT_TDATA  out  DATA_WIDTH  stream data.
- AXIS_OUT_TVALID  out  1  stream valid.
- AXIS_OUT_TREADY  in  1  stream ready.

Behaviour:
- Reset (async assert; release on the clk edge): state=IDLE, TVALID=0, TDATA=0, busy=0, done=0, rows_sent=0, pattern word v=SEED, inject flag=0, abort flag=0.
- A beat transfers only when TVALID&TREADY are both high. While TVALID=1 and TREADY=0, TDATA is held stable and TVALID stays high.
- State IDLE:
  - start with row_count!=0: latch row_count, v<=SEED, rows_sent<=0, busy<=1. The header appears on the very next cycle, so latency start->TVALID is 1 clk.
  - start with row_count==0: done pulses 1 clk later. No beats, busy stays 0.
- State HEADER: TDATA[511:504]=8'h02, TDATA[63:0]=row index (0-based), all other bits 0. On handshake -> DATA with beat counter=1.
- State DATA: lane k = TDATA[32k+31:32k], k=0..15. Lane k = v when k%4==0, v^FFFF_FFFF when k%4==1, v^AAAA_AAAA when k%4==2, v^5555_5555 when k%4==3.
  - On each handshake: v<=v+1, wrapping modulo 2^32. v is not reset between rows.
  - When the beat counter reaches DATA_CYCLES at handshake -> TRAILER.
- State TRAILER: TDATA[511:504]=8'h03, [63:0]=row index, [95:64]=DATA_CYCLES, other bits 0. On handshake rows_sent<=rows_sent+1.
  - If rows_sent+1==latched row_count, or the abort flag is set -> FINISH.
  - Otherwise -> GAP, or -> HEADER directly when GAP_CYCLES==0.
- State GAP: TVALID=0 for exactly GAP_CYCLES clks, then -> HEADER.
- State FINISH: done=1 and busy=0 for one clk, abort flag cleared, then -> IDLE. done asserts the cycle after the last trailer handshake.
- inject_error:
  - Sets a sticky flag.
  - The flag is applied to the first data beat presented after it is set: lane 1 bit 0 is inverted.
  - The flag clears on that beat's handshake. Exactly one beat is corrupted per pulse.
  - Pulses while the flag is already set are merged into one.
  - Ignored in IDLE.
- abort:
  - Sets a flag while busy. Ignored in IDLE.
  - Never drops TVALID mid-row; the current row always completes with header, all data beats and trailer.
  - abort during GAP ends the dataset immediately: -> FINISH, and no further header is sent.
- start while busy: ignored. row_count changes while busy have no effect.
- Simultaneous start and abort in IDLE: start wins, abort is ignored.
- rows_sent holds its value after done until the next accepted start.
- Reset asserted mid-row: immediate return to the reset values. The partial row is abandoned and the downstream watchdog handles it.

Test Plan:
- Reset, then start with row_count=2, GAP_CYCLES=0, TREADY=1 -> exactly 68 beats, back to back.
  - Header row0, data v=1..32, trailer; then header row1, data v=33..64, trailer.
  - done pulses at beat 68+1, rows_sent=2, busy low.
- row_count=1, TREADY toggling 1-0-1 at random -> 34 beats with TDATA stable during every stall; lane checks pass on all 32 data beats.
- SEED=32'hFFFF_FFFE, row_count=1 -> data beats carry v=FFFF_FFFE, FFFF_FFFF, 0000_0000, ...; lane 1 of the third beat = FFFF_FFFF.
- inject_error pulsed once during row 3 of 5 -> exactly one data beat has lane1 bit0 flipped; the downstream consumer ERRORS reads 1.
- abort pulsed mid-data of row 2 (row_count=10) -> row 2 completes with its trailer, done follows, rows_sent=3, no further headers.
- start with row_count=0 -> done pulses after 1 clk, TVALID never asserts. Then reset mid-row -> TVALID=0 asynchronously and busy=0.

Source files
------------

// File: rtl/axis_row_generator.sv
// -----------------------------------------------------------------------------
// axis_row_generator
//
// Streams complete data rows onto a 512-bit AXI Stream for the row-data
// consumer. Each row is one header beat, DATA_CYCLES data beats and one
// trailer beat. Data beats carry a lane-rotated integrity pattern built from a
// 32-bit word v that increments on every data handshake and continues across
// rows. GAP_CYCLES idle cycles may separate rows.
//
// Ports:
//   clk              single clock
//   reset            asynchronous, active-high
//   start            pulse; begins a dataset when idle
//   row_count        rows in the dataset, latched on an accepted start
//   abort            pulse; finish the dataset at the next row boundary
//   inject_error     pulse; invert lane 1 bit 0 of the next data beat
//   busy             high from accepted start until dataset end
//   done             one-cycle pulse at dataset end
//   rows_sent        trailers handshaken in the current/last dataset
//   AXIS_OUT_TDATA   stream data (all outputs registered)
//   AXIS_OUT_TVALID  stream valid
//   AXIS_OUT_TREADY  stream ready
// -----------------------------------------------------------------------------
module axis_row_generator #(
    parameter int          DATA_WIDTH  = 512,
    parameter int          DATA_CYCLES = 32,
    parameter int          GAP_CYCLES  = 0,
    parameter logic [31:0] SEED        = 32'h0000_0001
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [31:0]           row_count,
    input  logic                  abort,
    input  logic                  inject_error,
    output logic                  busy,
    output logic                  done,
    output logic [63:0]           rows_sent,
    output logic [DATA_WIDTH-1:0] AXIS_OUT_TDATA,
    output logic                  AXIS_OUT_TVALID,
    input  logic                  AXIS_OUT_TREADY
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HEADER  = 3'd1,
        S_DATA    = 3'd2,
        S_TRAILER = 3'd3,
        S_GAP     = 3'd4,
        S_FINISH  = 3'd5
    } state_t;

    localparam logic [31:0] DATA_CYCLES_W = 32'(DATA_CYCLES);
    localparam logic [31:0] GAP_LAST_W    = 32'(GAP_CYCLES - 1);
    localparam bit          NO_GAP        = (GAP_CYCLES == 32'sd0);

    // Lane k carries v XOR a mask chosen by k mod 4; flip inverts lane 1 bit 0.
    function automatic logic [DATA_WIDTH-1:0] data_beat(input logic [31:0] v,
                                                        input logic        flip);
        logic [DATA_WIDTH-1:0] beat;
        logic [1:0]            lane_sel;
        beat = '0;
        for (int k = 0; k < 16; k++) begin
            lane_sel = 2'(k);
            case (lane_sel)
                2'd0:    beat[32*k +: 32] = v;
                2'd1:    beat[32*k +: 32] = v ^ 32'hFFFF_FFFF;
                2'd2:    beat[32*k +: 32] = v ^ 32'hAAAA_AAAA;
                default: beat[32*k +: 32] = v ^ 32'h5555_5555;
            endcase
        end
        beat[32] = beat[32] ^ flip;
        return beat;
    endfunction

    // Header/trailer framing: tag in the top byte, row index low, count above it.
    function automatic logic [DATA_WIDTH-1:0] frame_beat(input logic [7:0]  tag,
                                                         input logic [63:0] row_idx,
                                                         input logic [31:0] count);
        logic [DATA_WIDTH-1:0] beat;
        beat                    = '0;
        beat[DATA_WIDTH-1 -: 8] = tag;
        beat[63:0]              = row_idx;
        beat[95:64]             = count;
        return beat;
    endfunction

    state_t                state_q, state_d;
    logic [31:0]           row_count_q, row_count_d;
    logic [31:0]           v_q, v_d;
    logic [63:0]           rows_sent_q, rows_sent_d;
    logic [31:0]           beat_cnt_q, beat_cnt_d;
    logic [31:0]           gap_cnt_q, gap_cnt_d;
    logic                  inject_q, inject_d;
    logic                  corrupt_q, corrupt_d;
    logic                  abort_q, abort_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  tvalid_q, tvalid_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                  hs_s;
    logic                  active_s;
    logic                  load_s;

    // Next-state, flag and next-beat computation.
    always_comb begin
        state_d     = state_q;
        row_count_d = row_count_q;
        v_d         = v_q;
        rows_sent_d = rows_sent_q;
        beat_cnt_d  = beat_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        corrupt_d   = corrupt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        tvalid_d    = tvalid_q;
        tdata_d     = tdata_q;
        load_s      = 1'b0;
        hs_s        = tvalid_q & AXIS_OUT_TREADY;
        active_s    = (state_q != S_IDLE) && (state_q != S_FINISH);

        if (active_s && abort) begin
            abort_d = 1'b1;
        end else begin
            abort_d = abort_q;
        end

        // The flag is consumed by the handshake of the beat that carried it;
        // a pulse arriving while it is pending merges into it.
        if (hs_s && corrupt_q) begin
            inject_d = 1'b0;
        end else if (active_s && inject_error) begin
            inject_d = 1'b1;
        end else begin
            inject_d = inject_q;
        end

        // A handshake retires the current beat; a stall keeps TDATA/TVALID.
        if (hs_s) begin
            tvalid_d  = 1'b0;
            tdata_d   = '0;
            corrupt_d = 1'b0;
        end else begin
            tvalid_d = tvalid_q;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (row_count != 32'd0) begin
                        row_count_d = row_count;
                        v_d         = SEED;
                        rows_sent_d = 64'd0;
                        busy_d      = 1'b1;
                        state_d     = S_HEADER;
                        load_s      = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HEADER: begin
                if (hs_s) begin
                    beat_cnt_d = 32'd1;
                    state_d    = S_DATA;
                    load_s     = 1'b1;
                end else begin
                    state_d = S_HEADER;
                end
            end
            S_DATA: begin
                if (hs_s) begin
                    v_d    = v_q + 32'd1;
                    load_s = 1'b1;
                    if (beat_cnt_q == DATA_CYCLES_W) begin
                        state_d = S_TRAILER;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 32'd1;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_TRAILER: begin
                if (hs_s) begin
                    rows_sent_d = rows_sent_q + 64'd1;
                    if ((rows_sent_d == {32'd0, row_count_q}) || abort_d) begin
                        state_d = S_FINISH;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else if (NO_GAP) begin
                        state_d = S_HEADER;
                        load_s  = 1'b1;
                    end else begin
                        state_d   = S_GAP;
                        gap_cnt_d = 32'd0;
                    end
                end else begin
                    state_d = S_TRAILER;
                end
            end
            S_GAP: begin
                if (abort_d) begin
                    state_d = S_FINISH;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else if (gap_cnt_q == GAP_LAST_W) begin
                    state_d = S_HEADER;
                    load_s  = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q + 32'd1;
                end
            end
            S_FINISH: begin
                abort_d = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d  = S_IDLE;
                busy_d   = 1'b0;
                tvalid_d = 1'b0;
                tdata_d  = '0;
            end
        endcase

        // Build the beat that the next state will present, so TDATA is a flop.
        if (load_s) begin
            tvalid_d = 1'b1;
            case (state_d)
                S_HEADER: begin
                    tdata_d   = frame_beat(8'h02, rows_sent_d, 32'd0);
                    corrupt_d = 1'b0;
                end
                S_DATA: begin
                    tdata_d   = data_beat(v_d, inject_d);
                    corrupt_d = inject_d;
                end
                S_TRAILER: begin
                    tdata_d   = frame_beat(8'h03, rows_sent_d, DATA_CYCLES_W);
                    corrupt_d = 1'b0;
                end
                default: begin
                    tvalid_d  = 1'b0;
                    tdata_d   = '0;
                    corrupt_d = 1'b0;
                end
            endcase
        end else begin
            load_s = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            row_count_q <= 32'd0;
            v_q         <= SEED;
            rows_sent_q <= 64'd0;
            beat_cnt_q  <= 32'd0;
            gap_cnt_q   <= 32'd0;
            inject_q    <= 1'b0;
            corrupt_q   <= 1'b0;
            abort_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            tvalid_q    <= 1'b0;
            tdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            row_count_q <= row_count_d;
            v_q         <= v_d;
            rows_sent_q <= rows_sent_d;
            beat_cnt_q  <= beat_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            inject_q    <= inject_d;
            corrupt_q   <= corrupt_d;
            abort_q     <= abort_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            tvalid_q    <= tvalid_d;
            tdata_q     <= tdata_d;
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign rows_sent       = rows_sent_q;
    assign AXIS_OUT_TDATA  = tdata_q;
    assign AXIS_OUT_TVALID = tvalid_q;

endmodule

// File: tb/tb_axis_row_generator.sv
module tb_axis_row_generator;

    localparam int          DC_A   = 32;
    localparam int          DC_B   = 4;
    localparam int          GAP_B  = 3;
    localparam logic [31:0] SEED_A = 32'h0000_0001;
    localparam logic [31:0] SEED_B = 32'hFFFF_FFFE;

    logic         clk = 1'b0;
    logic         reset, start, abort, inject_error, tready, sel;
    logic [31:0]  row_count;
    logic         start_a, start_b;
    logic         busy_a, done_a, tvalid_a, busy_b, done_b, tvalid_b;
    logic [63:0]  rows_a, rows_b;
    logic [511:0] tdata_a, tdata_b;
    logic         m_busy, m_done, m_tvalid;
    logic [63:0]  m_rows;
    logic [511:0] m_tdata;

    assign start_a  = start & ~sel;
    assign start_b  = start & sel;
    assign m_busy   = sel ? busy_b   : busy_a;
    assign m_done   = sel ? done_b   : done_a;
    assign m_tvalid = sel ? tvalid_b : tvalid_a;
    assign m_rows   = sel ? rows_b   : rows_a;
    assign m_tdata  = sel ? tdata_b  : tdata_a;

    axis_row_generator #(.DATA_WIDTH(512), .DATA_CYCLES(DC_A), .GAP_CYCLES(0), .SEED(SEED_A)) u_dut (
        .clk(clk), .reset(reset), .start(start_a), .row_count(row_count), .abort(abort),
        .inject_error(inject_error), .busy(busy_a), .done(done_a), .rows_sent(rows_a),
        .AXIS_OUT_TDATA(tdata_a), .AXIS_OUT_TVALID(tvalid_a), .AXIS_OUT_TREADY(tready));

    axis_row_generator #(.DATA_WIDTH(512), .DATA_CYCLES(DC_B), .GAP_CYCLES(GAP_B), .SEED(SEED_B)) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b), .row_count(row_count), .abort(abort),
        .inject_error(inject_error), .busy(busy_b), .done(done_b), .rows_sent(rows_b),
        .AXIS_OUT_TDATA(tdata_b), .AXIS_OUT_TVALID(tvalid_b), .AXIS_OUT_TREADY(tready));

    always #5 clk = ~clk;

    typedef struct {
        int rc;
        int rand_ready;
        int inject_at;
        int abort_at;
        int busy_start_at;
        int rows_exp;
        int done_lat;
        int use_b;
        int lane_check;
    } case_t;

    typedef struct {
        logic [511:0] data;
        bit           is_data;
    } beat_t;

    beat_t exp_q[$];
    int    total = 0;
    int    bad   = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] model_data(input logic [31:0] v);
        logic [511:0] b;
        logic [31:0]  m;
        b = '0;
        for (int k = 0; k < 16; k++) begin
            if (k % 4 == 0)      m = 32'h0000_0000;
            else if (k % 4 == 1) m = 32'hFFFF_FFFF;
            else if (k % 4 == 2) m = 32'hAAAA_AAAA;
            else                 m = 32'h5555_5555;
            b[32*k +: 32] = v ^ m;
        end
        return b;
    endfunction

    function automatic logic [511:0] model_frame(input logic [7:0] tag, input int row, input int cnt);
        logic [511:0] b;
        b          = '0;
        b[511:504] = tag;
        b[63:0]    = 64'(row);
        b[95:64]   = 32'(cnt);
        return b;
    endfunction

    task automatic push_dataset(input int rows, input int dc, input logic [31:0] seed);
        logic [31:0] v;
        beat_t       e;
        v = seed;
        for (int r = 0; r < rows; r++) begin
            e.data = model_frame(8'h02, r, 0); e.is_data = 1'b0; exp_q.push_back(e);
            for (int d = 0; d < dc; d++) begin
                e.data = model_data(v); e.is_data = 1'b1; exp_q.push_back(e);
                v = v + 32'd1;
            end
            e.data = model_frame(8'h03, r, dc); e.is_data = 1'b0; exp_q.push_back(e);
        end
    endtask

    task automatic run_case(input case_t c);
        int           dc, bpr, hs_cnt, done_due, flips, flip_idx, gap_cnt, exp_gap;
        bit           in_gap, stalled, inj_done, ab_done, bs_done, seen_done;
        logic [511:0] held, flip_mask;
        beat_t        e;
        sel       = c.use_b[0];
        dc        = c.use_b != 0 ? DC_B : DC_A;
        exp_gap   = c.use_b != 0 ? GAP_B : 0;
        bpr       = dc + 2;
        flip_mask = '0;
        flip_mask[32] = 1'b1;
        exp_q.delete();
        push_dataset(c.rows_exp, dc, c.use_b != 0 ? SEED_B : SEED_A);
        hs_cnt = 0; done_due = -1; flips = 0; flip_idx = -1; gap_cnt = 0;
        in_gap = 0; stalled = 0; inj_done = 0; ab_done = 0; bs_done = 0; seen_done = 0;
        held = '0;
        for (int i = 0; i < 3000 && !seen_done; i++) begin
            @(negedge clk);
            start = 1'b0; abort = 1'b0; inject_error = 1'b0;
            if (i == 0) begin
                start = 1'b1; row_count = 32'(c.rc);
            end
            if (i == 1) begin
                check("start_latency_tvalid", 512'(m_tvalid), 512'd1);
                check("busy_after_start", 512'(m_busy), 512'd1);
            end
            if (stalled) begin
                check("stall_tvalid", 512'(m_tvalid), 512'd1);
                check("stall_tdata", m_tdata, held);
            end
            if (in_gap) begin
                if (m_tvalid) begin
                    check("gap_length", 512'(gap_cnt), 512'(exp_gap));
                    in_gap = 0;
                end else begin
                    gap_cnt++;
                end
            end
            if (m_done) begin
                check("done_timing", 512'(i), 512'(done_due));
                check("busy_at_done", 512'(m_busy), 512'd0);
                check("tvalid_at_done", 512'(m_tvalid), 512'd0);
                check("rows_sent_at_done", 512'(m_rows), 512'(c.rows_exp));
                seen_done = 1;
            end else begin
                if (!inj_done && c.inject_at >= 0 && hs_cnt == c.inject_at) begin
                    inject_error = 1'b1; inj_done = 1;
                end
                if (!ab_done && c.abort_at >= 0 && hs_cnt == c.abort_at) begin
                    abort = 1'b1; ab_done = 1;
                end
                if (!bs_done && c.busy_start_at >= 0 && hs_cnt == c.busy_start_at) begin
                    start = 1'b1; row_count = 32'd7; bs_done = 1;
                end
                tready  = (c.rand_ready != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
                stalled = m_tvalid && !tready;
                held    = m_tdata;
                if (m_tvalid && tready) begin
                    if (exp_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL extra_beat: got beat %0d expected none", hs_cnt);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.is_data && m_tdata === (e.data ^ flip_mask)) begin
                            flips++;
                            flip_idx = hs_cnt;
                        end else begin
                            check("beat_data", m_tdata, e.data);
                        end
                        if (c.lane_check != 0 && hs_cnt == 3)
                            check("seed_wrap_lane1", 512'(m_tdata[63:32]), 512'(32'hFFFF_FFFF));
                        hs_cnt++;
                        if (hs_cnt % bpr == 0 && exp_q.size() != 0) begin
                            in_gap = 1; gap_cnt = 0;
                        end
                        if (exp_q.size() == 0) done_due = i + c.done_lat;
                    end
                end
            end
        end
        if (!seen_done) begin
            total++; bad++;
            $display("FAIL done_timeout: got no done expected done after %0d beats", c.rows_exp * bpr);
        end
        check("beats_remaining", 512'(exp_q.size()), 512'd0);
        check("corrupted_beats", 512'(flips), 512'(c.inject_at >= 0 ? 1 : 0));
        if (c.inject_at >= 0) check("corrupted_beat_index", 512'(flip_idx), 512'(c.inject_at + 1));
        tready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("idle_tvalid", 512'(m_tvalid), 512'd0);
            check("idle_done", 512'(m_done), 512'd0);
            check("rows_sent_hold", 512'(m_rows), 512'(c.rows_exp));
        end
    endtask

    case_t cases[8];

    initial begin
        // rc, rand_ready, inject_at, abort_at, busy_start_at, rows_exp, done_lat, use_b, lane_check
        cases[0] = '{2, 0, -1, -1, -1, 2, 1, 0, 0};   // back-to-back 68 beats
        cases[1] = '{1, 1, -1, -1, 20, 1, 1, 0, 0};   // random ready, start while busy
        cases[2] = '{5, 0, 73, -1, -1, 5, 1, 0, 0};   // inject in row index 2
        cases[3] = '{10, 0, -1, 78, -1, 3, 1, 0, 0};  // abort mid-data of row index 2
        cases[4] = '{3, 1, 3, -1, -1, 3, 1, 0, 0};    // inject under random stalls
        cases[5] = '{2, 0, -1, 0, -1, 2, 1, 0, 0};    // abort together with start
        cases[6] = '{2, 0, -1, -1, -1, 2, 1, 1, 1};   // seed wrap, gap rows
        cases[7] = '{5, 0, -1, 6, -1, 1, 2, 1, 0};    // abort during gap

        reset = 1'b0; start = 1'b0; abort = 1'b0; inject_error = 1'b0;
        tready = 1'b0; sel = 1'b0; row_count = 32'd0;
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_tvalid", 512'(tvalid_a), 512'd0);
        check("reset_tdata", tdata_a, 512'd0);
        check("reset_busy", 512'(busy_a), 512'd0);
        check("reset_done", 512'(done_a), 512'd0);
        check("reset_rows_sent", 512'(rows_a), 512'd0);
        check("reset_b_tvalid", 512'(tvalid_b), 512'd0);

        for (int n = 0; n < 8; n++) run_case(cases[n]);

        // Empty dataset: done one clock after start, no beats.
        sel = 1'b0; tready = 1'b1;
        @(negedge clk);
        start = 1'b1; row_count = 32'd0;
        @(negedge clk);
        start = 1'b0;
        check("zero_rows_done", 512'(done_a), 512'd1);
        check("zero_rows_busy", 512'(busy_a), 512'd0);
        check("zero_rows_tvalid", 512'(tvalid_a), 512'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("zero_rows_after_done", 512'(done_a), 512'd0);
            check("zero_rows_after_tvalid", 512'(tvalid_a), 512'd0);
        end

        // Reset in the middle of the second row.
        start = 1'b1; row_count = 32'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        check("pre_reset_rows_sent", 512'(rows_a), 512'd1);
        check("pre_reset_tvalid", 512'(tvalid_a), 512'd1);
        reset = 1'b1;
        #1;
        check("async_reset_tvalid", 512'(tvalid_a), 512'd0);
        check("async_reset_busy", 512'(busy_a), 512'd0);
        check("async_reset_rows_sent", 512'(rows_a), 512'd0);
        check("async_reset_tdata", tdata_a, 512'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("post_reset_tvalid", 512'(tvalid_a), 512'd0);
            check("post_reset_busy", 512'(busy_a), 512'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
